// File: rtl/key_sequencer_pkg.sv
// Shared types and constants for the key sequencer: FSM states, key bit
// positions and a small helper used to size the repeat timer.
package key_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        WAIT_RELEASE
    } seq_state_t;

    localparam int unsigned KEY_CLR = 0;
    localparam int unsigned KEY_INC = 1;
    localparam int unsigned KEY_DEC = 2;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_sequencer_if.sv
// Push-button side and command side of the key sequencer bundled together.
// The master drives the raw buttons, the slave (the sequencer) returns the
// command pulses and the debounced key state.
interface key_sequencer_if;

    logic [2:0] key_n;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       clr_pulse;
    logic [2:0] keys_pressed;

    modport master (
        output key_n,
        input  inc_pulse,
        input  dec_pulse,
        input  clr_pulse,
        input  keys_pressed
    );

    modport slave (
        input  key_n,
        output inc_pulse,
        output dec_pulse,
        output clr_pulse,
        output keys_pressed
    );

endinterface

// File: rtl/key_debounce.sv
// One push-button: two-flop synchronizer followed by a stability counter.
// The accepted level only flips after the synchronized level has disagreed
// with it long enough; any agreeing sample restarts the count.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_meta;
    logic             sync_key;
    logic [CNT_W-1:0] stable_cnt;
    logic             pressed_q;

    // Synchronize the raw button, then count how long it disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta  <= 1'b1;
            sync_key   <= 1'b1;
            stable_cnt <= '0;
            pressed_q  <= 1'b0;
        end else begin
            sync_meta <= key_n;
            sync_key  <= sync_meta;
            if ((~sync_key) != pressed_q) begin
                if (stable_cnt == CNT_LAST) begin
                    pressed_q  <= ~sync_key;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

    assign pressed = pressed_q;

endmodule

// File: rtl/key_sequencer.sv
// Turns three debounced push-buttons into one-cycle clear/inc/dec commands,
// with auto-repeat for inc and dec while the key stays held.
module key_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic           clk,
    input  logic           reset,
    key_sequencer_if.slave bus
);

    import key_sequencer_pkg::*;

    localparam int unsigned TIMER_MAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int TIMER_W = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    logic [2:0]         pressed;
    seq_state_t         state, state_next;
    logic [1:0]         owner, owner_next;
    logic [1:0]         opposite;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               inc_q, dec_q, clr_q;
    logic               inc_next, dec_next, clr_next;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .key_n   (bus.key_n[i]),
            .pressed (pressed[i])
        );
    end

    assign opposite = (owner == 2'(KEY_INC)) ? 2'(KEY_DEC) : 2'(KEY_INC);

    // Register the FSM state, the repeating key, the timer and the command pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            timer <= '0;
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            timer <= timer_next;
            inc_q <= inc_next;
            dec_q <= dec_next;
            clr_q <= clr_next;
        end
    end

    // Decide the next state and which single command, if any, fires next cycle.
    always_comb begin
        state_next = state;
        owner_next = owner;
        timer_next = timer;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        clr_next   = 1'b0;
        case (state)
            IDLE: begin
                timer_next = '0;
                if (pressed[KEY_CLR]) begin
                    clr_next   = 1'b1;
                    state_next = WAIT_RELEASE;
                end else if (pressed[KEY_INC] ^ pressed[KEY_DEC]) begin
                    owner_next = pressed[KEY_INC] ? 2'(KEY_INC) : 2'(KEY_DEC);
                    inc_next   = pressed[KEY_INC];
                    dec_next   = pressed[KEY_DEC];
                    state_next = HOLD;
                end else if (pressed[KEY_INC] && pressed[KEY_DEC]) begin
                    state_next = WAIT_RELEASE;
                end
            end
            HOLD, REPEAT: begin
                if (pressed[KEY_CLR]) begin
                    clr_next   = 1'b1;
                    state_next = WAIT_RELEASE;
                end else if (!pressed[owner]) begin
                    state_next = IDLE;
                end else if (pressed[opposite]) begin
                    state_next = WAIT_RELEASE;
                end else if (timer == ((state == HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
                    inc_next   = (owner == 2'(KEY_INC));
                    dec_next   = (owner == 2'(KEY_DEC));
                    timer_next = '0;
                    state_next = REPEAT;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (pressed == 3'b000) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.inc_pulse    = inc_q;
    assign bus.dec_pulse    = dec_q;
    assign bus.clr_pulse    = clr_q;
    assign bus.keys_pressed = pressed;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer with short debounce/repeat times.
// A cycle-level reference model built from the accept-after-stable rule and
// absolute repeat deadlines predicts every output on every cycle; directed
// scenarios add explicit timing expectations on top.
module tb_key_sequencer;

    localparam int DEB    = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 3;
    localparam int HIST_N = 8192;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    key_sequencer_if kbus ();

    key_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (DELAY),
        .REPEAT_PERIOD   (PERIOD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kbus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit [2:0] hist [0:HIST_N-1];
    bit [2:0] db_m      = 3'b000;
    int       owner_m   = -1;
    bit       waiting_m = 1'b0;
    int       next_fire = 0;
    bit       exp_inc   = 1'b0;
    bit       exp_dec   = 1'b0;
    bit       exp_clr   = 1'b0;

    int inc_q[$];
    int dec_q[$];
    int clr_q[$];

    // Free-running 100 MHz-style bench clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc - 1);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] keys, input int cycles);
        kbus.key_n = keys;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic bit [2:0] histAt(input int idx);
        if (idx < 0 || idx >= HIST_N) return 3'b000;
        return hist[idx];
    endfunction

    // Reference model: one step per clock edge, predicting the outputs that edge registers.
    always @(posedge clk) begin : model_step
        int       e;
        bit [2:0] dbp;
        bit       all_diff;
        e = cyc;
        exp_inc = 1'b0;
        exp_dec = 1'b0;
        exp_clr = 1'b0;
        if (reset) begin
            if (e < HIST_N) hist[e] = 3'b000;
            if (e > 0 && e - 1 < HIST_N) hist[e-1] = 3'b000;
            db_m      = 3'b000;
            owner_m   = -1;
            waiting_m = 1'b0;
        end else begin
            if (e < HIST_N) hist[e] = ~kbus.key_n;
            dbp = db_m;
            if (owner_m >= 0) begin
                if (dbp[0]) begin
                    exp_clr   = 1'b1;
                    owner_m   = -1;
                    waiting_m = 1'b1;
                end else if (!dbp[owner_m]) begin
                    owner_m = -1;
                end else if (dbp[3-owner_m]) begin
                    owner_m   = -1;
                    waiting_m = 1'b1;
                end else if (e == next_fire) begin
                    exp_inc   = (owner_m == 1);
                    exp_dec   = (owner_m == 2);
                    next_fire = e + PERIOD;
                end
            end else if (waiting_m) begin
                if (dbp == 3'b000) waiting_m = 1'b0;
            end else begin
                if (dbp[0]) begin
                    exp_clr   = 1'b1;
                    waiting_m = 1'b1;
                end else if (dbp[1] ^ dbp[2]) begin
                    owner_m   = dbp[1] ? 1 : 2;
                    exp_inc   = dbp[1];
                    exp_dec   = dbp[2];
                    next_fire = e + DELAY;
                end else if (dbp[1] && dbp[2]) begin
                    waiting_m = 1'b1;
                end
            end
            // A key level is accepted once the last DEB+1 synchronized samples all disagree with it.
            for (int k = 0; k < 3; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j <= DEB; j++) begin
                    if (histAt(e - 2 - j)[k] == db_m[k]) all_diff = 1'b0;
                end
                if (all_diff) db_m[k] = ~db_m[k];
            end
        end
        cyc = cyc + 1;
    end

    // Compare every cycle against the model and log when each pulse occurred.
    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("inc_pulse", kbus.inc_pulse, exp_inc);
            checkOutput("dec_pulse", kbus.dec_pulse, exp_dec);
            checkOutput("clr_pulse", kbus.clr_pulse, exp_clr);
            checkOutput("keys_pressed", kbus.keys_pressed, db_m);
            checkOutput("one_pulse_max",
                        ($countones({kbus.clr_pulse, kbus.dec_pulse, kbus.inc_pulse}) <= 1), 1);
            if (kbus.inc_pulse) inc_q.push_back(cyc - 1);
            if (kbus.dec_pulse) dec_q.push_back(cyc - 1);
            if (kbus.clr_pulse) clr_q.push_back(cyc - 1);
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized press sequence.
    initial begin
        int t0;
        int r;
        int after_clr;
        int exp_inc_at[4];
        exp_inc_at = '{7, 15, 18, 21};
        kbus.key_n = 3'b111;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_keys", kbus.keys_pressed, 0);
        checkOutput("reset_pulses", {kbus.clr_pulse, kbus.dec_pulse, kbus.inc_pulse}, 0);
        reset = 1'b0;
        applyStimulus(3'b111, 3);

        // Held inc: first pulse, then delay and period repeats, stop on release.
        inc_q.delete();
        t0 = cyc;
        applyStimulus(3'b101, 17);
        applyStimulus(3'b111, 20);
        checkOutput("hold_inc_count", inc_q.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("hold_inc_time", (i < inc_q.size()) ? inc_q[i] - t0 : -1, exp_inc_at[i]);

        // Bouncing dec never settles long enough to be accepted.
        dec_q.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b011, 2);
            applyStimulus(3'b111, 2);
        end
        applyStimulus(3'b111, 15);
        checkOutput("bounce_dec_count", dec_q.size(), 0);
        checkOutput("bounce_keys", kbus.keys_pressed, 0);

        // Clear during inc auto-repeat preempts it exactly once.
        inc_q.delete();
        clr_q.delete();
        t0 = cyc;
        applyStimulus(3'b101, 20);
        applyStimulus(3'b100, 20);
        applyStimulus(3'b111, 25);
        checkOutput("preempt_clr_count", clr_q.size(), 1);
        checkOutput("preempt_clr_time", (clr_q.size() > 0) ? clr_q[0] - t0 : -1, 27);
        checkOutput("preempt_inc_before", inc_q.size(), 5);
        after_clr = 0;
        foreach (inc_q[i]) if (clr_q.size() > 0 && inc_q[i] > clr_q[0]) after_clr++;
        checkOutput("preempt_inc_after", after_clr, 0);

        // Inc and dec together: no pulse, then a later inc proves the FSM is idle again.
        inc_q.delete();
        dec_q.delete();
        clr_q.delete();
        applyStimulus(3'b001, 15);
        applyStimulus(3'b111, 15);
        checkOutput("both_no_pulse", inc_q.size() + dec_q.size() + clr_q.size(), 0);
        t0 = cyc;
        applyStimulus(3'b101, 8);
        applyStimulus(3'b111, 12);
        checkOutput("both_then_inc_count", inc_q.size(), 1);
        checkOutput("both_then_inc_time", (inc_q.size() > 0) ? inc_q[0] - t0 : -1, 7);

        // One-cycle reset in HOLD with inc still held.
        applyStimulus(3'b101, 10);
        reset = 1'b1;
        t0 = cyc;
        @(negedge clk);
        checkOutput("hold_reset_pulses", {kbus.clr_pulse, kbus.dec_pulse, kbus.inc_pulse}, 0);
        checkOutput("hold_reset_keys", kbus.keys_pressed, 0);
        reset = 1'b0;
        inc_q.delete();
        applyStimulus(3'b101, 8);
        applyStimulus(3'b111, 15);
        checkOutput("after_reset_inc_count", inc_q.size(), 1);
        checkOutput("after_reset_inc_time", (inc_q.size() > 0) ? inc_q[0] - t0 : -1, 8);

        // Random presses, holds and occasional resets against the model.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 29);
            if (r == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            applyStimulus(3'($urandom_range(0, 7)), $urandom_range(1, 20));
        end
        applyStimulus(3'b111, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
